// File: rtl/divider_unit.sv
// Multi-cycle radix-2 restoring divider producing quotient (LO) and remainder (HI).
// Signed operation is compiled in only when DIVIDER_SIGNED_EN is defined.
module divider_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             stall,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             load, step, finish;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvsr, dvnd_raw;
  logic [WIDTH-1:0] rem_next, quo_next, q_result, r_result;
  logic [WIDTH-1:0] mag_dividend, mag_divisor;
  logic [WIDTH:0]   partial;
  logic             take, zero_div;

`ifdef DIVIDER_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  always_comb begin
    a_neg        = signed_op & dividend[WIDTH-1];
    b_neg        = signed_op & divisor[WIDTH-1];
    mag_dividend = a_neg ? -dividend : dividend;
    mag_divisor  = b_neg ? -divisor : divisor;
  end
`else
  logic unused_signed_op;

  assign mag_dividend     = dividend;
  assign mag_divisor      = divisor;
  assign unused_signed_op = signed_op;
`endif

  // One restoring step; the true difference is below dvsr, so the low WIDTH bits suffice.
  always_comb begin
    partial  = {rem, quo[WIDTH-1]};
    take     = partial >= {1'b0, dvsr};
    rem_next = take ? (partial[WIDTH-1:0] - dvsr) : partial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], take};
    if (zero_div) begin
      q_result = '1;
      r_result = dvnd_raw;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      q_result = neg_q ? -quo_next : quo_next;
      r_result = neg_r ? -rem_next : rem_next;
`else
      q_result = quo_next;
      r_result = rem_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    stall      = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          stall      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST_STEP) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        valid = 1'b1;
        if (start && !flush) begin
          load       = 1'b1;
          stall      = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      dvnd_raw    <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      if (load) begin
        dvnd_raw <= dividend;
        dvsr     <= mag_divisor;
        quo      <= mag_dividend;
        rem      <= '0;
        count    <= '0;
        zero_div <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
`endif
      end else if (step) begin
        rem   <= rem_next;
        quo   <= quo_next;
        count <= count + CW'(1);
      end
      if (finish) begin
        quotient    <= q_result;
        remainder   <= r_result;
        div_by_zero <= zero_div;
      end
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_divider_unit;
  localparam int unsigned W = 32;
`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, signed_op, flush;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         valid, stall, div_by_zero;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_q, last_r;
  logic         last_z;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    string        name;
  } vec_t;

  divider_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .flush(flush),
    .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .valid(valid), .stall(stall), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic; SV signed / and % already truncate toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s && SIGNED_EN) begin
      if (a == most_neg && b == '1) begin
        q = most_neg;
        r = '0;
      end else begin
        q = W'($signed(a) / $signed(b));
        r = W'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of cycle 0; returns in the valid cycle (sample point).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input string name);
    int lat;
    bit stall_ok;
    lat = 0;
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    #2;
    stall_ok = (stall === 1'b1);
    for (int n = 1; n <= 40; n++) begin
      tick();
      start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
      #2;
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    if (lat != 0 && stall !== 1'b0) stall_ok = 1'b0;
    chk({name, " latency"}, 64'(lat), 64'(W + 1));
    chk({name, " stall"}, 64'(stall_ok), 64'd1);
    chk({name, " quotient"}, 64'(quotient), 64'(eq));
    chk({name, " remainder"}, 64'(remainder), 64'(er));
    chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    last_q = eq; last_r = er; last_z = ez;
  endtask

  initial begin
    vec_t         tbl[10];
    logic [W-1:0] eq, er, a, b;
    logic         ez, s;
    int           nv, first;
    bit           seen;
    logic [W-1:0] cap_q, cap_r;

    tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100/7"};
    tbl[1] = '{32'hFFFFFFF9, 32'd2, 1'b1,
               SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC,
               SIGNED_EN ? 32'hFFFFFFFF : 32'd1, 1'b0, "s-7/2"};
    tbl[2] = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, "u/0"};
    tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
               SIGNED_EN ? 32'h80000000 : 32'd0,
               SIGNED_EN ? 32'd0 : 32'h80000000, 1'b0, "smin/-1"};
    tbl[4] = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, "u0/5"};
    tbl[5] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, "umax/1"};
    tbl[6] = '{32'd5, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd5, 1'b0, "u5/max"};
    tbl[7] = '{32'd7, 32'hFFFFFFFE, 1'b1,
               SIGNED_EN ? 32'hFFFFFFFD : 32'd0,
               SIGNED_EN ? 32'd1 : 32'd7, 1'b0, "s7/-2"};
    tbl[8] = '{32'hFFFFFFF8, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1, "s-8/0"};
    tbl[9] = '{32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, "u1000/10"};

    reset = 1'b1; start = 1'b0; flush = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    tick(); tick(); #2;
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      tick();
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].name);
    end

    // Back-to-back: the second start lands in the first operation's DONE cycle.
    tick();
    run_op(32'd81, 32'd4, 1'b0, 32'd20, 32'd1, 1'b0, "b2b first");
    run_op(32'd99, 32'd10, 1'b0, 32'd9, 32'd9, 1'b0, "b2b second");

    // Flush in RUN cycle 10.
    tick();
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    flush = 1'b1;
    #2;
    chk("flush run stall", 64'(stall), 64'd1);
    tick();
    flush = 1'b0;
    #2;
    chk("flush valid", 64'(valid), 64'd0);
    chk("flush stall", 64'(stall), 64'd0);
    chk("flush quotient held", 64'(quotient), 64'(last_q));
    chk("flush remainder held", 64'(remainder), 64'(last_r));
    chk("flush dbz held", 64'(div_by_zero), 64'(last_z));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(); #2;
      if (valid === 1'b1) seen = 1'b1;
    end
    chk("flush no valid", 64'(seen), 64'd0);

    // Start during RUN cycle 12 is ignored.
    tick();
    start = 1'b1; dividend = 32'd200; divisor = 32'd9; signed_op = 1'b0;
    nv = 0; first = 0; cap_q = '0; cap_r = '0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      start = (c == 12);
      if (c == 12) begin
        dividend = 32'd50; divisor = 32'd5;
      end
      #2;
      if (valid === 1'b1) begin
        nv++;
        if (first == 0) begin
          first = c; cap_q = quotient; cap_r = remainder;
        end
      end
    end
    chk("ignore valid count", 64'(nv), 64'd1);
    chk("ignore latency", 64'(first), 64'(W + 1));
    chk("ignore quotient", 64'(cap_q), 64'd22);
    chk("ignore remainder", 64'(cap_r), 64'd2);

    // Reset in RUN cycle 5.
    tick();
    start = 1'b1; dividend = 32'd77; divisor = 32'd0; signed_op = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("rst-run quotient", 64'(quotient), 64'd0);
    chk("rst-run remainder", 64'(remainder), 64'd0);
    chk("rst-run valid", 64'(valid), 64'd0);
    chk("rst-run stall", 64'(stall), 64'd0);
    chk("rst-run div_by_zero", 64'(div_by_zero), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(); #2;
      if (valid === 1'b1) seen = 1'b1;
    end
    chk("rst-run no valid", 64'(seen), 64'd0);

    // Flush beats start in IDLE.
    tick();
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #2;
    chk("flush-start stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #2;
    chk("flush-start not running", 64'(stall), 64'd0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = $urandom_range(0, 2);
        default: b = -($urandom_range(1, 100));
      endcase
      s = 1'($urandom_range(0, 1));
      if (i % 10 == 0) begin
        a = 32'h80000000; b = '1; s = 1'b1;
      end
      model(a, b, s, eq, er, ez);
      tick();
      run_op(a, b, s, eq, er, ez, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division with the current operands.
REQ-005 The block SHALL have port signed_op, input, 1 bit: 1 = two's-complement divide, 0 = unsigned divide.
REQ-006 The block SHALL have port flush, input, 1 bit: cancel any operation in progress.
REQ-007 The block SHALL have port dividend, input, WIDTH bits: numerator.
REQ-008 The block SHALL have port divisor, input, WIDTH bits: denominator.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result destined for LO.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: result destined for HI.
REQ-011 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking the cycle in which results are new.
REQ-012 The block SHALL have port stall, output, 1 bit: when high, the upstream pipeline register enable is deasserted (enable = ~stall).
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: the completed operation had divisor == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 with flush=0 SHALL latch dividend, divisor and signed_op, clear the iteration counter and enter RUN; otherwise DONE SHALL go to IDLE after one cycle.
REQ-016 RUN SHALL perform one radix-2 restoring step per cycle for exactly WIDTH cycles, then enter DONE.
REQ-017 The timing SHALL be: start accepted at cycle 0, RUN for cycles 1..WIDTH, and valid=1 in cycle WIDTH+1 only.
REQ-018 stall SHALL be 1 when (state==IDLE or DONE) and start=1 and flush=0, and also whenever state==RUN; it SHALL be 0 otherwise.
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold their values until the next DONE or a reset.
REQ-020 start asserted while in RUN SHALL be ignored, with no queuing.
REQ-021 flush=1 in any state SHALL force IDLE on the next edge with no valid pulse, leave the result outputs unchanged, and take priority over start.
REQ-022 An unsigned divide SHALL produce quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor.
REQ-023 A signed divide SHALL iterate on magnitudes; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend (truncation toward zero).
REQ-024 A signed divide of most-negative by -1 SHALL give quotient = most-negative and remainder = 0, with no flag.
REQ-025 When divisor == 0, in either mode, the block SHALL give quotient = all ones, remainder = dividend and div_by_zero = 1; it SHALL still take the full latency.
REQ-026 The operand inputs SHALL be don't-care after the start cycle; only the latched copies are used.

Reset
REQ-027 reset=1 SHALL take priority over flush and start, and on the next edge force IDLE, quotient=0, remainder=0, valid=0, div_by_zero=0, counter=0 and all internal registers to 0.
REQ-028 Reset asserted during RUN SHALL abandon the operation with no valid pulse; stall SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-029 The macro DIVIDER_SIGNED_EN SHALL control signed support.
REQ-030 With DIVIDER_SIGNED_EN defined, signed_op SHALL be honoured as in REQ-023/REQ-024.
REQ-031 Without DIVIDER_SIGNED_EN, signed_op SHALL be ignored, every operation SHALL be unsigned, and the sign-fixup logic SHALL be absent; the port SHALL remain present.

Verification
REQ-032 The bench SHALL check: unsigned 100/7 -> valid exactly 33 cycles after start (WIDTH=32), quotient=14, remainder=2, stall high for cycles 0..32.
REQ-033 The bench SHALL check: signed -7/2 with DIVIDER_SIGNED_EN -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; without the macro -> quotient=0x7FFFFFFC, remainder=1.
REQ-034 The bench SHALL check: 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same latency as REQ-032.
REQ-035 The bench SHALL check: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-036 The bench SHALL check: flush at cycle 10 of RUN -> IDLE next cycle, no valid, stall=0, previous results retained; a second start in cycle 12 of RUN -> ignored.
REQ-037 The bench SHALL check: reset at cycle 5 of RUN -> next cycle all outputs 0; start in the DONE cycle -> next division accepted back-to-back, valid WIDTH+1 cycles later.
